// File: rtl/fire_out_packer.sv
// Write-side packer: gathers four 16-lane result beats into one 64-lane activation
// word, applies optional ReLU, and drives the ping-pong activation memory write port.
module fire_out_packer #(
  parameter int DW        = 16,
  parameter int LANES_IN  = 16,
  parameter int LANES_OUT = 64,
  parameter int AW        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    relu_en,
  input  logic [AW-1:0]           base_addr,
  input  logic [2:0]              firesel_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES_IN*DW-1:0]  in_data,
  input  logic                    in_last,
  input  logic                    mem_ready,
  output logic                    wren,
  output logic [AW-1:0]           address1,
  output logic [2:0]              firesel,
  output logic [LANES_OUT*DW-1:0] datain,
  output logic                    bank,
  output logic                    layer_done
);

  localparam int NB = LANES_OUT / LANES_IN;
  localparam int BW = LANES_IN * DW;
  localparam int CW = $clog2(NB);

  logic [CW-1:0] beat_cnt;
  logic [AW-1:0] word_idx;
  logic [AW-1:0] base_q;
  logic [2:0]    fire_q;
  logic          pend;
  logic          last_pend;
  logic          in_layer;
  logic [BW-1:0] stage [NB-1];

  logic                    accept;
  logic                    wr_done;
  logic                    layer_end;
  logic                    layer_open;
  logic                    complete;
  logic [AW-1:0]           cur_base;
  logic [2:0]              cur_fire;
  logic [AW-1:0]           word_sel;
  logic [BW-1:0]           beat_relu;
  logic [LANES_OUT*DW-1:0] packed_word;

  assign wren       = pend;
  assign in_ready   = rst && (!pend || mem_ready);
  assign accept     = in_valid && in_ready;
  assign wr_done    = pend && mem_ready;
  assign layer_end  = wr_done && last_pend;
  // A beat accepted in the same cycle the layer's last word retires starts the next layer.
  assign layer_open = in_layer && !layer_end;
  assign complete   = accept && ((beat_cnt == CW'(NB - 1)) || in_last);
  assign cur_base   = layer_open ? base_q : base_addr;
  assign cur_fire   = layer_open ? fire_q : firesel_in;
  assign word_sel   = layer_end ? '0 : (word_idx + AW'(wr_done));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    beat_relu = in_data;
    for (int i = 0; i < LANES_IN; i++) begin
      if (relu_en && in_data[i*DW + DW - 1]) beat_relu[i*DW +: DW] = '0;
    end
  end

  always_comb begin
    packed_word = '0;
    for (int k = 0; k < NB - 1; k++) begin
      if (int'(beat_cnt) > k) packed_word[k*BW +: BW] = stage[k];
    end
    packed_word[int'(beat_cnt)*BW +: BW] = beat_relu;
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the
  // block deliberately override earlier ones (e.g. a new transfer keeps pend set).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt   <= '0;
      word_idx   <= '0;
      base_q     <= '0;
      fire_q     <= '0;
      pend       <= 1'b0;
      last_pend  <= 1'b0;
      in_layer   <= 1'b0;
      address1   <= '0;
      firesel    <= '0;
      datain     <= '0;
      bank       <= 1'b0;
      layer_done <= 1'b0;
      // NOTE: the staging array is small and register-based, so it is reset along with
      // everything else; no partial beat survives a reset.
      for (int k = 0; k < NB - 1; k++) stage[k] <= '0;
    end else begin
      layer_done <= layer_end;

      if (layer_end) begin
        bank     <= ~bank;
        word_idx <= '0;
        in_layer <= 1'b0;
      end else if (wr_done) begin
        word_idx <= word_idx + AW'(1);
      end

      if (wr_done) begin
        pend      <= 1'b0;
        last_pend <= 1'b0;
      end

      if (accept) begin
        in_layer <= 1'b1;
        if (!layer_open) begin
          base_q <= base_addr;
          fire_q <= firesel_in;
        end
        if (complete) begin
          datain    <= packed_word;
          address1  <= cur_base + word_sel * AW'(LANES_OUT);
          firesel   <= cur_fire;
          pend      <= 1'b1;
          last_pend <= in_last;
          beat_cnt  <= '0;
        end else begin
          stage[beat_cnt] <= beat_relu;
          beat_cnt        <= beat_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fire_out_packer.sv
// Self-checking bench for fire_out_packer: directed scenarios plus randomized traffic
// scored against a beat-list reference model of the packing and layer rules.
module tb_fire_out_packer;

  localparam int DW = 16;
  localparam int LI = 16;
  localparam int LO = 64;
  localparam int AW = 32;
  localparam int BW = LI * DW;
  localparam int WW = LO * DW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    fire;
    logic [WW-1:0] data;
    bit            last;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          relu_en = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [2:0]    firesel_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          mem_ready = 1'b1;
  logic          wren;
  logic [AW-1:0] address1;
  logic [2:0]    firesel;
  logic [WW-1:0] datain;
  logic          bank;
  logic          layer_done;

  always #5 clk = ~clk;

  fire_out_packer #(.DW(DW), .LANES_IN(LI), .LANES_OUT(LO), .AW(AW)) dut (
    .clk(clk), .rst(rst), .relu_en(relu_en), .base_addr(base_addr),
    .firesel_in(firesel_in), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .mem_ready(mem_ready), .wren(wren),
    .address1(address1), .firesel(firesel), .datain(datain), .bank(bank),
    .layer_done(layer_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  wr_t           exp_q[$];
  logic [BW-1:0] m_beats[4];
  int            m_cnt = 0;
  bit            m_in_layer = 0;
  logic [AW-1:0] m_base = '0;
  logic [2:0]    m_fire = '0;
  int            m_words = 0;
  bit            m_bank = 0;
  bit            exp_ld = 0;

  bit            accepted;
  bit            rand_mr = 0;
  int            wr_cycles[$];
  logic [AW-1:0] wr_addrs[$];
  logic [WW-1:0] last_wr_data = '0;

  function automatic logic [BW-1:0] relu_of(input logic [BW-1:0] b, input logic en);
    logic [BW-1:0] r;
    for (int i = 0; i < LI; i++) begin
      logic signed [DW-1:0] v;
      v = b[i*DW +: DW];
      r[i*DW +: DW] = (en && v < 0) ? '0 : v;
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] d;
    for (int w = 0; w < BW / 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_cnt      = 0;
    m_in_layer = 0;
    m_words    = 0;
    m_bank     = 0;
    exp_ld     = 0;
  endtask

  task automatic model_accept();
    wr_t e;
    if (!m_in_layer) begin
      m_base     = base_addr;
      m_fire     = firesel_in;
      m_in_layer = 1;
      m_words    = 0;
    end
    m_beats[m_cnt] = relu_of(in_data, relu_en);
    m_cnt++;
    if (m_cnt == 4 || in_last) begin
      e.data = '0;
      for (int k = 0; k < m_cnt; k++) e.data[k*BW +: BW] = m_beats[k];
      e.addr = m_base + 32'(m_words) * 32'd64;
      e.fire = m_fire;
      e.last = in_last;
      exp_q.push_back(e);
      m_words++;
      m_cnt = 0;
      if (in_last) m_in_layer = 0;
    end
  endtask

  // One clock: sample just after the falling edge, score writes/accepts, advance.
  task automatic step();
    wr_t e;
    #1;
    accepted = 0;
    if (rst) begin
      checks++;
      if (layer_done !== exp_ld) begin
        errors++;
        $display("FAIL layer_done cycle %0d got %b want %b", cyc, layer_done, exp_ld);
      end
      checks++;
      if (bank !== m_bank) begin
        errors++;
        $display("FAIL bank cycle %0d got %b want %b", cyc, bank, m_bank);
      end
      exp_ld = 0;
      if (wren === 1'b1 && mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write cycle %0d got addr %h want none", cyc, address1);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (address1 !== e.addr) begin
            errors++;
            $display("FAIL write_addr cycle %0d got %h want %h", cyc, address1, e.addr);
          end
          checks++;
          if (firesel !== e.fire) begin
            errors++;
            $display("FAIL write_firesel cycle %0d got %0d want %0d", cyc, firesel, e.fire);
          end
          checks++;
          if (datain !== e.data) begin
            errors++;
            for (int j = 0; j < LO; j++) begin
              if (datain[j*DW +: DW] !== e.data[j*DW +: DW]) begin
                $display("FAIL write_data cycle %0d elem %0d got %h want %h", cyc, j,
                         datain[j*DW +: DW], e.data[j*DW +: DW]);
                break;
              end
            end
          end
          if (e.last) begin
            m_bank = ~m_bank;
            exp_ld = 1;
          end
        end
        wr_cycles.push_back(cyc);
        wr_addrs.push_back(address1);
        last_wr_data = datain;
      end
      if (in_valid && in_ready === 1'b1) begin
        model_accept();
        accepted = 1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send_beat(input logic [BW-1:0] d, input logic last, output int tries);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tries    = 0;
    do begin
      if (rand_mr) mem_ready = ($urandom_range(0, 3) != 0);
      step();
      tries++;
    end while (!accepted && tries < 100);
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL accept_timeout got %0d tries want acceptance", tries);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      if (rand_mr) mem_ready = ($urandom_range(0, 3) != 0);
      step();
    end
  endtask

  task automatic drain();
    int t = 0;
    in_valid  = 1'b0;
    rand_mr   = 0;
    mem_ready = 1'b1;
    while ((exp_q.size() != 0 || wren === 1'b1) && t < 100) begin
      step();
      t++;
    end
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d words outstanding want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({wren, address1, firesel, datain, bank, layer_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wren %b addr %h fire %0d bank %b done %b want all 0",
               wren, address1, firesel, bank, layer_done);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [BW-1:0] b;
    logic [WW-1:0] want;
    int tries;
    base_addr = 32'd0; firesel_in = 3'd3; relu_en = 1'b0; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < LI; i++) b[i*DW +: DW] = DW'(k * 16 + i + 1);
      send_beat(b, k == 3, tries);
    end
    for (int j = 0; j < LO; j++) want[j*DW +: DW] = DW'(j + 1);
    checks++;
    if (wren !== 1'b1 || address1 !== 32'd0) begin
      errors++;
      $display("FAIL basic_wren got wren %b addr %h want 1 and 0", wren, address1);
    end
    checks++;
    if (datain !== want) begin
      errors++;
      $display("FAIL basic_data got elem0 %h elem63 %h want 0001 and 0040",
               datain[DW-1:0], datain[WW-1 -: DW]);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int n0, tries;
    n0 = wr_addrs.size();
    base_addr = 32'd1000; firesel_in = 3'd5; mem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send_beat(rand_beat(), k == 7, tries);
      checks++;
      if (tries != 1) begin
        errors++;
        $display("FAIL b2b_in_ready beat %0d got %0d cycles want 1", k, tries);
      end
    end
    drain();
    checks++;
    if (wr_addrs.size() != n0 + 2) begin
      errors++;
      $display("FAIL b2b_count got %0d writes want 2", wr_addrs.size() - n0);
    end else begin
      checks++;
      if (wr_addrs[n0] !== 32'd1000 || wr_addrs[n0+1] !== 32'd1064) begin
        errors++;
        $display("FAIL b2b_addr got %0d,%0d want 1000,1064", wr_addrs[n0], wr_addrs[n0+1]);
      end
    end
  endtask

  task automatic test_relu();
    logic [DW-1:0] vin[4];
    logic [DW-1:0] vout[4];
    logic [BW-1:0] b;
    logic [WW-1:0] want;
    int tries;
    vin  = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001};
    vout = '{16'h0000, 16'h0000, 16'h7FFF, 16'h0001};
    want = '0;
    for (int i = 0; i < LI; i++) begin
      b[i*DW +: DW]    = vin[i % 4];
      want[i*DW +: DW] = vout[i % 4];
    end
    relu_en = 1'b1; base_addr = 32'd4000; firesel_in = 3'd1;
    send_beat(b, 1'b1, tries);
    drain();
    relu_en = 1'b0;
    checks++;
    if (last_wr_data !== want) begin
      errors++;
      $display("FAIL relu got lanes %h %h %h %h want 0000 0000 7fff 0001",
               last_wr_data[0 +: DW], last_wr_data[DW +: DW],
               last_wr_data[2*DW +: DW], last_wr_data[3*DW +: DW]);
    end
  endtask

  task automatic test_layer_end();
    logic [BW-1:0] b[6];
    logic b0;
    int tries;
    b0 = bank;
    base_addr = 32'd5000; firesel_in = 3'd2; mem_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b[k] = rand_beat();
      send_beat(b[k], k == 5, tries);
    end
    drain();
    checks++;
    if (last_wr_data !== {{(2*BW){1'b0}}, b[5], b[4]}) begin
      errors++;
      $display("FAIL last_partial got slot2 %h slot0 %h want 0 and %h",
               last_wr_data[2*BW +: DW], last_wr_data[0 +: DW], b[4][0 +: DW]);
    end
    checks++;
    if (wr_addrs[wr_addrs.size()-1] !== 32'd5064) begin
      errors++;
      $display("FAIL last_addr got %0d want 5064", wr_addrs[wr_addrs.size()-1]);
    end
    checks++;
    if (bank !== ~b0) begin
      errors++;
      $display("FAIL bank_toggle got %b want %b", bank, ~b0);
    end
    base_addr = 32'd7000;
    for (int k = 0; k < 4; k++) send_beat(rand_beat(), k == 3, tries);
    drain();
    checks++;
    if (wr_addrs[wr_addrs.size()-1] !== 32'd7000) begin
      errors++;
      $display("FAIL next_layer_addr got %0d want 7000", wr_addrs[wr_addrs.size()-1]);
    end
  endtask

  task automatic test_stall();
    logic [WW-1:0] sd;
    logic [AW-1:0] sa;
    logic [BW-1:0] nb;
    int tries;
    base_addr = 32'd300; firesel_in = 3'd6; mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) send_beat(rand_beat(), 1'b0, tries);
    mem_ready = 1'b0;
    sd = datain;
    sa = address1;
    checks++;
    if (sa !== 32'd300) begin
      errors++;
      $display("FAIL stall_addr got %0d want 300", sa);
    end
    nb = rand_beat();
    in_valid = 1'b1; in_data = nb;
    for (int s = 0; s < 5; s++) begin
      step();
      checks++;
      if (wren !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ctrl cycle %0d got wren %b in_ready %b want 1 0", s, wren, in_ready);
      end
      checks++;
      if (datain !== sd || address1 !== sa) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got addr %h want %h", s, address1, sa);
      end
    end
    mem_ready = 1'b1;
    send_beat(nb, 1'b0, tries);
    checks++;
    if (tries != 1) begin
      errors++;
      $display("FAIL stall_release got %0d cycles want 1", tries);
    end
    for (int k = 0; k < 3; k++) send_beat(rand_beat(), k == 2, tries);
    drain();
  endtask

  task automatic test_reset_mid();
    logic [BW-1:0] b[4];
    int tries;
    base_addr = 32'h100; mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) send_beat(rand_beat(), 1'b0, tries);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({wren, address1, firesel, datain, bank, layer_done, in_ready} !== '0) begin
      errors++;
      $display("FAIL midreset_partial got wren %b addr %h bank %b ready %b want 0",
               wren, address1, bank, in_ready);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    base_addr = 32'h180; mem_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_beat(rand_beat(), 1'b0, tries);
    checks++;
    if (wren !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pending got wren %b want 1", wren);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({wren, address1, firesel, datain, bank, layer_done} !== '0) begin
      errors++;
      $display("FAIL midreset_write got wren %b addr %h want 0", wren, address1);
    end
    model_clear();
    mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    base_addr = 32'h200; firesel_in = 3'd4;
    for (int k = 0; k < 4; k++) begin
      b[k] = rand_beat();
      send_beat(b[k], k == 3, tries);
    end
    drain();
    checks++;
    if (wr_addrs[wr_addrs.size()-1] !== 32'h200 || last_wr_data !== {b[3], b[2], b[1], b[0]}) begin
      errors++;
      $display("FAIL post_reset_word got addr %h want %h", wr_addrs[wr_addrs.size()-1], 32'h200);
    end
  endtask

  task automatic test_random();
    int tries;
    logic last;
    rand_mr = 1;
    for (int n = 0; n < 300; n++) begin
      relu_en    = 1'($urandom_range(0, 1));
      base_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FF80 + 32'($urandom_range(0, 127))
                                               : 32'($urandom);
      firesel_in = 3'($urandom_range(0, 7));
      last       = (n == 299) || ($urandom_range(0, 6) == 0);
      send_beat(rand_beat(), last, tries);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    drain();
    relu_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish by 500us");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_relu();
    test_layer_end();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fire_out_packer.md
Name: fire_out_packer

Overview:
- Write-side packer between the 16-lane convolution/fire PE array and the ping-pong activation memory.
- Accepts 16-lane x 16-bit result beats over a valid/ready handshake, applies optional ReLU, and packs four beats into one 64-lane x 16-bit memory word.
- Generates the memory write strobe, element address and fire-layer select for each packed word.
- Marks layer completion and toggles the ping/pong bank select for the next layer.

Parameters:
- DW, 16, bits per activation element (signed two's complement).
- LANES_IN, 16, elements per input beat.
- LANES_OUT, 64, elements per memory word; must equal 4*LANES_IN.
- AW, 32, address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- relu_en  in  1  1 = clamp negative elements to 0 before packing.
- base_addr  in  AW  element address of word 0 of the layer; sampled on the first accepted beat of a layer.
- firesel_in  in  3  layer id; sampled with base_addr.
- in_valid  in  1  input beat valid.
- in_ready  out  1  packer can accept a beat this cycle.
- in_data  in  LANES_IN*DW  beat; lane i at [i*DW +: DW].
- in_last  in  1  beat is the final beat of the layer.
- mem_ready  in  1  memory accepts a write this cycle.
- wren  out  1  packed word pending; write occurs when wren && mem_ready.
- address1  out  AW  element address of the pending word.
- firesel  out  3  layer id of the pending word.
- datain  out  LANES_OUT*DW  packed word; beat k, lane i at [(k*16+i)*DW +: DW].
- bank  out  1  ping/pong bank select for the current layer.
- layer_done  out  1  one-cycle pulse after the last word of a layer is written.

Behaviour:
- Reset (rst=0, asynchronous): outputs and state are cleared.
  - wren=0, datain=0, address1=0, firesel=0, bank=0, layer_done=0.
  - beat_cnt=0, word_idx=0, pend=0, in_layer=0.
  - in_ready=0 while rst=0, and 1 in the first cycle after release.
- Beat acceptance: a beat is accepted when in_valid && in_ready.
  - in_ready = !pend || mem_ready. With mem_ready held high, throughput is 1 beat/cycle.
- ReLU: when relu_en=1, any lane with MSB=1 is replaced by 0; other lanes pass unchanged. No other arithmetic is applied.
- Packing:
  - Each accepted beat is written into slot beat_cnt of a staging register, and beat_cnt increments.
  - On the 4th beat (beat_cnt==3), or on any beat with in_last=1, the staging word is transferred to datain in the same edge, with unfilled slots zeroed.
  - On that transfer: pend=1, wren=1, address1 = base + word_idx*LANES_OUT, beat_cnt=0.
- Latency: datain/wren are valid the cycle after the completing beat is accepted.
- Write completion: in a cycle where wren && mem_ready:
  - word_idx increments.
  - If no new word is transferred in the same cycle, pend=0 and wren=0.
  - If a new word is transferred in the same cycle, pend stays 1 and datain/address1 update (back-to-back writes).
- Stall: while wren=1 and mem_ready=0, datain, address1 and firesel hold stable and in_ready=0.
- Layer start: the first accepted beat with in_layer=0 latches base_addr/firesel_in and sets in_layer=1. That beat uses the new base directly.
- Layer end (word transferred by an in_last beat): when that word is written (wren && mem_ready):
  - layer_done=1 for the next cycle only.
  - bank toggles, word_idx=0, in_layer=0.
- in_last on the 1st beat: a single word with slots 1..3 zeroed.
- Address wrap: address1 arithmetic is modulo 2^AW; no saturation.
- Reset mid-operation: the partial staging word and pending write are discarded with no write strobe; bank returns to 0.

Test Plan:
- Four beats, each lane = beat*16+lane+1, base_addr=0, relu_en=0, mem_ready=1 -> one wren pulse the cycle after beat 4; address1=0; datain element j = j+1 for j=0..63.
- Eight consecutive beats, base_addr=1000 -> address1=1000 then 1064 on consecutive write cycles; in_ready stays 1 throughout.
- relu_en=1, lanes 0x8000, 0xFFFF, 0x7FFF, 0x0001 -> packed values 0, 0, 0x7FFF, 0x0001.
- Six beats with in_last on beat 6 -> second word has slots 0-1 filled and slots 2-3 zero; layer_done pulses one cycle after that write; bank goes 0->1; next layer restarts at word_idx=0.
- Hold mem_ready=0 for 5 cycles with a word pending -> wren=1 with datain/address1 stable, in_ready=0, no beats lost; on release the write completes and the next beats are accepted.
- Assert rst low after 2 beats and while a write is pending -> all outputs go to 0 immediately; after release a full 4-beat sequence produces a word at address base+0 with no residue from the aborted beats.
